// File: rtl/time_keeper.sv
// time_keeper: BCD time-of-day counter with a small set-mode FSM.
//
// The divider's slow sec_clk level is sampled as data. Each rising edge
// becomes a one-cycle tick, and that tick advances seconds, minutes and
// hours in BCD. The mode button cycles RUN -> SET_HR -> SET_MIN -> RUN.
// In the SET_* modes, up/down adjust the selected field.
//
// state   | meaning
// --------+----------------------------------------------------------
// RUN     | time advances on ticks; colon follows sec_clk
// SET_HR  | up/down adjust hours; ticks ignored; blink follows sec_clk
// SET_MIN | up/down adjust minutes; ticks ignored; blink follows sec_clk
//
// Ports:
//   clk                      system clock
//   reset                    synchronous active-low reset
//   sec_clk                  divider output, sampled as data
//   mode_btn/up_btn/down_btn one-cycle debounced button pulses
//   hr_tens/hr_units         BCD hours
//   min_tens/min_units       BCD minutes
//   mode                     00 RUN, 01 SET_HR, 10 SET_MIN
//   blink                    registered sec_clk in SET_*, else 0
//   colon                    registered sec_clk in RUN, else 0

module time_keeper #(
   parameter int HOUR_MAX      = 24,
   parameter int TICKS_PER_MIN = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sec_clk,
   input  logic       mode_btn,
   input  logic       up_btn,
   input  logic       down_btn,
   output logic [3:0] hr_tens,
   output logic [3:0] hr_units,
   output logic [3:0] min_tens,
   output logic [3:0] min_units,
   output logic [1:0] mode,
   output logic       blink,
   output logic       colon
);

   localparam int SW = (TICKS_PER_MIN > 2) ? $clog2(TICKS_PER_MIN) : 1;
   localparam logic [SW-1:0] SEC_LAST  = SW'(TICKS_PER_MIN - 1);
   localparam logic [3:0]    HR_LAST_T = 4'((HOUR_MAX - 1) / 10);
   localparam logic [3:0]    HR_LAST_U = 4'((HOUR_MAX - 1) % 10);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      SET_HR  = 2'b01,
      SET_MIN = 2'b10
   } mode_e;

   mode_e         mode_q, mode_d;
   logic [7:0]    hr_q, hr_d;
   logic [7:0]    min_q, min_d;
   logic [SW-1:0] sec_q, sec_d;
   logic          sec_clk_q;
   logic          blink_q, blink_d;
   logic          colon_q, colon_d;
   logic          tick;

   // Two-digit BCD increment that wraps to 00 after {last_t,last_u}.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                          input logic [3:0] last_t,
                                          input logic [3:0] last_u);
      if (v == {last_t, last_u})
         return 8'h00;
      else if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Two-digit BCD decrement that wraps from 00 to {last_t,last_u}.
   function automatic logic [7:0] bcd_dec(input logic [7:0] v,
                                          input logic [3:0] last_t,
                                          input logic [3:0] last_u);
      if (v == 8'h00)
         return {last_t, last_u};
      else if (v[3:0] == 4'd0)
         return {v[7:4] - 4'd1, 4'd9};
      else
         return {v[7:4], v[3:0] - 4'd1};
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         mode_q    <= RUN;
         hr_q      <= 8'h00;
         min_q     <= 8'h00;
         sec_q     <= '0;
         // Load the live level so a high sec_clk at release is not a tick.
         sec_clk_q <= sec_clk;
         blink_q   <= 1'b0;
         colon_q   <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         hr_q      <= hr_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         sec_clk_q <= sec_clk;
         blink_q   <= blink_d;
         colon_q   <= colon_d;
      end
   end

   always_comb begin
      tick   = sec_clk & ~sec_clk_q;
      mode_d = mode_q;
      hr_d   = hr_q;
      min_d  = min_q;
      sec_d  = sec_q;

      if (mode_btn) begin
         // A mode change takes priority over any up/down in the same cycle.
         case (mode_q)
            RUN: begin
               mode_d = SET_HR;
               sec_d  = '0;
            end
            SET_HR:  mode_d = SET_MIN;
            SET_MIN: begin
               mode_d = RUN;
               sec_d  = '0;
            end
            default: mode_d = RUN;
         endcase
      end else begin
         case (mode_q)
            RUN: begin
               if (tick) begin
                  if (sec_q == SEC_LAST) begin
                     sec_d = '0;
                     min_d = bcd_inc(min_q, 4'd5, 4'd9);
                     if (min_q == 8'h59)
                        hr_d = bcd_inc(hr_q, HR_LAST_T, HR_LAST_U);
                  end else begin
                     sec_d = sec_q + SW'(1);
                  end
               end
            end
            SET_HR: begin
               if (up_btn && !down_btn)
                  hr_d = bcd_inc(hr_q, HR_LAST_T, HR_LAST_U);
               else if (down_btn && !up_btn)
                  hr_d = bcd_dec(hr_q, HR_LAST_T, HR_LAST_U);
            end
            SET_MIN: begin
               if (up_btn && !down_btn)
                  min_d = bcd_inc(min_q, 4'd5, 4'd9);
               else if (down_btn && !up_btn)
                  min_d = bcd_dec(min_q, 4'd5, 4'd9);
            end
            default: mode_d = RUN;
         endcase
      end

      // Follow the new mode so the indicators switch on the same edge.
      blink_d = (mode_d != RUN) & sec_clk;
      colon_d = (mode_d == RUN) & sec_clk;
   end

   assign hr_tens   = hr_q[7:4];
   assign hr_units  = hr_q[3:0];
   assign min_tens  = min_q[7:4];
   assign min_units = min_q[3:0];
   assign mode      = mode_q;
   assign blink     = blink_q;
   assign colon     = colon_q;

endmodule

// File: tb/tb_time_keeper.sv
module tb_time_keeper;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic sec_clk = 1'b0;
   logic mode_btn = 1'b0, up_btn = 1'b0, down_btn = 1'b0;
   logic m12 = 1'b0, u12 = 1'b0, d12 = 1'b0;

   logic [3:0] hr_tens, hr_units, min_tens, min_units;
   logic [1:0] mode;
   logic       blink, colon;
   logic [3:0] hr_tens12, hr_units12, min_tens12, min_units12;
   logic [1:0] mode12;
   logic       blink12, colon12;

   logic [15:0] tod, tod12;
   assign tod   = {hr_tens, hr_units, min_tens, min_units};
   assign tod12 = {hr_tens12, hr_units12, min_tens12, min_units12};

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   time_keeper #(.HOUR_MAX(24), .TICKS_PER_MIN(4)) dut (
      .clk(clk), .reset(reset), .sec_clk(sec_clk),
      .mode_btn(mode_btn), .up_btn(up_btn), .down_btn(down_btn),
      .hr_tens(hr_tens), .hr_units(hr_units),
      .min_tens(min_tens), .min_units(min_units),
      .mode(mode), .blink(blink), .colon(colon)
   );

   time_keeper #(.HOUR_MAX(12), .TICKS_PER_MIN(4)) dut12 (
      .clk(clk), .reset(reset), .sec_clk(sec_clk),
      .mode_btn(m12), .up_btn(u12), .down_btn(d12),
      .hr_tens(hr_tens12), .hr_units(hr_units12),
      .min_tens(min_tens12), .min_units(min_units12),
      .mode(mode12), .blink(blink12), .colon(colon12)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic edge_sec();
      sec_clk = 1'b1;
      step();
      sec_clk = 1'b0;
      step();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      sec_clk = 1'b0;
      mode_btn = 1'b0; up_btn = 1'b0; down_btn = 1'b0;
      m12 = 1'b0; u12 = 1'b0; d12 = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic press_mode();
      mode_btn = 1'b1; step(); mode_btn = 1'b0;
   endtask

   task automatic press_up();
      up_btn = 1'b1; step(); up_btn = 1'b0;
   endtask

   task automatic press_down();
      down_btn = 1'b1; step(); down_btn = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      sec_clk = 1'b1;
      repeat (3) step();
      tests++;
      if (tod !== 16'h0000) begin fails++; $display("FAIL reset_tod got %h want 0000", tod); end
      tests++;
      if ({mode, blink, colon} !== 4'b0000) begin
         fails++; $display("FAIL reset_flags got mode=%b blink=%b colon=%b want 00 0 0", mode, blink, colon);
      end
      reset = 1'b1;
      repeat (5) step();
      tests++;
      if (tod !== 16'h0000 || mode !== 2'b00) begin
         fails++; $display("FAIL release_hold got %h mode=%b want 0000 mode=00", tod, mode);
      end
      tests++;
      if (colon !== 1'b1 || blink !== 1'b0) begin
         fails++; $display("FAIL release_colon got colon=%b blink=%b want 1 0", colon, blink);
      end
      sec_clk = 1'b0;
      step();
      repeat (3) edge_sec();
      tests++;
      if (tod !== 16'h0000) begin fails++; $display("FAIL no_spurious_tick got %h want 0000", tod); end
      sec_clk = 1'b1;
      step();
      tests++;
      if (tod !== 16'h0001) begin fails++; $display("FAIL first_minute got %h want 0001", tod); end
      sec_clk = 1'b0;
      step();
   endtask

   task automatic test_count();
      do_reset();
      repeat (3) edge_sec();
      sec_clk = 1'b1;
      tests++;
      if (tod !== 16'h0000) begin fails++; $display("FAIL count_pre got %h want 0000", tod); end
      step();
      tests++;
      if (tod !== 16'h0001) begin fails++; $display("FAIL count_latency got %h want 0001", tod); end
      sec_clk = 1'b0;
      step();
      repeat (35) edge_sec();
      tests++;
      if (tod !== 16'h0009) begin fails++; $display("FAIL count_39 got %h want 0009", tod); end
      edge_sec();
      tests++;
      if (tod !== 16'h0010) begin fails++; $display("FAIL count_40 got %h want 0010", tod); end
   endtask

   task automatic test_set_hours();
      do_reset();
      press_mode();
      tests++;
      if (mode !== 2'b01) begin fails++; $display("FAIL sethr_mode got %b want 01", mode); end
      press_down();
      tests++;
      if (tod !== 16'h2300) begin fails++; $display("FAIL sethr_down got %h want 2300", tod); end
      press_up();
      tests++;
      if (tod !== 16'h0000) begin fails++; $display("FAIL sethr_up1 got %h want 0000", tod); end
      press_up();
      tests++;
      if (tod !== 16'h0100) begin fails++; $display("FAIL sethr_up2 got %h want 0100", tod); end
      sec_clk = 1'b1;
      step();
      tests++;
      if (blink !== 1'b1 || colon !== 1'b0) begin
         fails++; $display("FAIL blink_high got blink=%b colon=%b want 1 0", blink, colon);
      end
      sec_clk = 1'b0;
      step();
      tests++;
      if (blink !== 1'b0) begin fails++; $display("FAIL blink_low got %b want 0", blink); end
      repeat (9) press_up();
      tests++;
      if (tod !== 16'h1000) begin fails++; $display("FAIL sethr_carry got %h want 1000", tod); end
   endtask

   task automatic test_set_minutes();
      do_reset();
      press_mode();
      press_mode();
      tests++;
      if (mode !== 2'b10) begin fails++; $display("FAIL setmin_mode got %b want 10", mode); end
      press_down();
      tests++;
      if (tod !== 16'h0059) begin fails++; $display("FAIL setmin_down got %h want 0059", tod); end
      press_up();
      tests++;
      if (tod !== 16'h0000) begin fails++; $display("FAIL setmin_up got %h want 0000", tod); end
      repeat (10) edge_sec();
      tests++;
      if (tod !== 16'h0000) begin fails++; $display("FAIL setmin_ticks got %h want 0000", tod); end
      repeat (10) press_up();
      tests++;
      if (tod !== 16'h0010) begin fails++; $display("FAIL setmin_carry got %h want 0010", tod); end
      press_mode();
      tests++;
      if (mode !== 2'b00) begin fails++; $display("FAIL setmin_exit got %b want 00", mode); end
      repeat (3) edge_sec();
      tests++;
      if (tod !== 16'h0010) begin fails++; $display("FAIL resume_3 got %h want 0010", tod); end
      edge_sec();
      tests++;
      if (tod !== 16'h0011) begin fails++; $display("FAIL resume_4 got %h want 0011", tod); end
   endtask

   task automatic test_rollover();
      do_reset();
      repeat (2) edge_sec();
      press_mode();
      press_down();
      press_mode();
      press_down();
      press_mode();
      tests++;
      if (tod !== 16'h2359 || mode !== 2'b00) begin
         fails++; $display("FAIL roll_setup got %h mode=%b want 2359 mode=00", tod, mode);
      end
      repeat (3) edge_sec();
      tests++;
      if (tod !== 16'h2359) begin fails++; $display("FAIL roll_pre got %h want 2359", tod); end
      sec_clk = 1'b1;
      step();
      tests++;
      if (tod !== 16'h0000) begin fails++; $display("FAIL roll_wrap got %h want 0000", tod); end
      sec_clk = 1'b0;
      step();
   endtask

   task automatic test_contention();
      do_reset();
      press_mode();
      up_btn = 1'b1; down_btn = 1'b1; step(); up_btn = 1'b0; down_btn = 1'b0;
      tests++;
      if (tod !== 16'h0000) begin fails++; $display("FAIL both_hr got %h want 0000", tod); end
      mode_btn = 1'b1; up_btn = 1'b1; step(); mode_btn = 1'b0; up_btn = 1'b0;
      tests++;
      if (tod !== 16'h0000 || mode !== 2'b10) begin
         fails++; $display("FAIL mode_up got %h mode=%b want 0000 mode=10", tod, mode);
      end
      up_btn = 1'b1; down_btn = 1'b1; step(); up_btn = 1'b0; down_btn = 1'b0;
      tests++;
      if (tod !== 16'h0000) begin fails++; $display("FAIL both_min got %h want 0000", tod); end
      mode_btn = 1'b1; down_btn = 1'b1; step(); mode_btn = 1'b0; down_btn = 1'b0;
      tests++;
      if (tod !== 16'h0000 || mode !== 2'b00) begin
         fails++; $display("FAIL mode_down got %h mode=%b want 0000 mode=00", tod, mode);
      end
      press_up();
      press_down();
      tests++;
      if (tod !== 16'h0000 || mode !== 2'b00) begin
         fails++; $display("FAIL run_buttons got %h mode=%b want 0000 mode=00", tod, mode);
      end
   endtask

   task automatic test_hour12();
      do_reset();
      m12 = 1'b1; step(); m12 = 1'b0;
      tests++;
      if (mode12 !== 2'b01) begin fails++; $display("FAIL h12_mode got %b want 01", mode12); end
      d12 = 1'b1; step(); d12 = 1'b0;
      tests++;
      if (tod12 !== 16'h1100) begin fails++; $display("FAIL h12_down got %h want 1100", tod12); end
      u12 = 1'b1; step(); u12 = 1'b0;
      tests++;
      if (tod12 !== 16'h0000) begin fails++; $display("FAIL h12_up got %h want 0000", tod12); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      press_mode();
      press_mode();
      press_down();
      sec_clk = 1'b1;
      step();
      reset = 1'b0;
      step();
      tests++;
      if (tod !== 16'h0000 || mode !== 2'b00 || blink !== 1'b0 || colon !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid got %h mode=%b blink=%b colon=%b want 0000 00 0 0", tod, mode, blink, colon);
      end
      reset = 1'b1;
      sec_clk = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_count();
      test_set_hours();
      test_set_minutes();
      test_rollover();
      test_contention();
      test_hour12();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
